delay_predic_stage: RTL and testbench



---
 rtl/delay_predic_stage.sv | 93 +++++++++
 tb/tb_delay_predic_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/delay_predic_stage.sv
// One tap of the G.726 sixth-order zero predictor: delays the float DQ by one
// sample and adapts the tap coefficient B with sign-sign gain and leakage.
module delay_predic_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] DQ,
  input  logic [10:0] DQN,
  input  logic [1:0]  RATE,
  input  logic        TR,
  input  logic        test_mode,
  input  logic        scan_enable,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  output logic [10:0] DQN1,
  output logic [15:0] B,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  localparam logic [10:0] DQN1_RESET = 11'h020;

  logic [10:0] dqn1_r;
  logic [15:0] b_r;
  logic [15:0] gain_s;
  logic [15:0] leak_s;
  logic [15:0] bp_s;
  logic [15:0] br_s;
  logic        dft_sink_s;

  // Sign-sign gain: zero when DQ is zero, otherwise +/-128 by sign agreement.
  function automatic logic [15:0] sign_gain(input logic [15:0] dq, input logic dns);
    logic [15:0] g;
    if (dq[14:0] == 15'd0) begin
      g = 16'h0000;
    end else if (dq[15] ^ dns) begin
      g = 16'hFF80;
    end else begin
      g = 16'h0080;
    end
    return g;
  endfunction

  // 40 kbit/s leaks by 2^-9, the other rates by 2^-8 (arithmetic shift).
  function automatic logic [15:0] leak_term(input logic [15:0] b, input logic [1:0] rate);
    logic [15:0] l;
    case (rate)
      2'b00:   l = {{9{b[15]}}, b[15:9]};
      default: l = {{8{b[15]}}, b[15:8]};
    endcase
    return l;
  endfunction

  // Next coefficient from the current registered B and delayed DQ sign.
  always_comb begin
    gain_s = sign_gain(DQ, dqn1_r[10]);
    leak_s = leak_term(b_r, RATE);
    bp_s   = b_r + gain_s - leak_s;
    if (TR) begin
      br_s = 16'h0000;
    end else begin
      br_s = bp_s;
    end
  end

  // Sample-rate state: delayed DQ float and coefficient.
  always_ff @(posedge clk) begin
    if (reset) begin
      dqn1_r <= DQN1_RESET;
      b_r    <= 16'h0000;
    end else begin
      dqn1_r <= DQN;
      b_r    <= br_s;
    end
  end

  assign DQN1 = dqn1_r;
  assign B    = b_r;

  // DFT hooks are tied off until scan insertion replaces them.
  assign dft_sink_s = ^{test_mode, scan_enable, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};
  assign scan_out0  = dft_sink_s & 1'b0;
  assign scan_out1  = 1'b0;
  assign scan_out2  = 1'b0;
  assign scan_out3  = 1'b0;
  assign scan_out4  = 1'b0;

endmodule

// File: tb/tb_delay_predic_stage.sv
// Self-checking bench for delay_predic_stage: directed cases plus randomized
// stimulus against an integer-arithmetic reference model.
module tb_delay_predic_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] DQ;
  logic [10:0] DQN;
  logic [1:0]  RATE;
  logic        TR;
  logic        test_mode, scan_enable;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic [10:0] DQN1;
  logic [15:0] B;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_b;
  logic [10:0] m_dqn1;

  delay_predic_stage dut (
    .clk(clk), .reset(reset), .DQ(DQ), .DQN(DQN), .RATE(RATE), .TR(TR),
    .test_mode(test_mode), .scan_enable(scan_enable),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .DQN1(DQN1), .B(B),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int r;
    r = a % d;
    if (r < 0) r = r + d;
    return (a - r) / d;
  endfunction

  // Reference: one sample of the G.726 coefficient update, in plain integers.
  task automatic model_step();
    int g, nb;
    if (reset) begin
      m_b    = 0;
      m_dqn1 = 11'h020;
    end else begin
      if (DQ[14:0] == 15'd0) g = 0;
      else if (DQ[15] != m_dqn1[10]) g = -128;
      else g = 128;
      nb = m_b + g - floor_div(m_b, (RATE == 2'b00) ? 512 : 256);
      nb = ((nb % 65536) + 65536) % 65536;
      if (nb >= 32768) nb = nb - 65536;
      if (TR) nb = 0;
      m_b    = nb;
      m_dqn1 = DQN;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eb;
    eb = m_b[15:0];
    check_val({tag, "_B"}, B, eb);
    check_val({tag, "_DQN1"}, {5'd0, DQN1}, {5'd0, m_dqn1});
  endtask

  initial begin
    reset = 1'b1; DQ = 16'h0000; DQN = 11'h000; RATE = 2'b01; TR = 1'b0;
    test_mode = 1'b0; scan_enable = 1'b0;
    scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;
    m_b = 12345; m_dqn1 = 11'h7FF;

    // 1: reset
    tick();
    check_val("rst_B", B, 16'h0000);
    check_val("rst_DQN1", {5'd0, DQN1}, 16'h0020);
    check_val("scan_out", {11'd0, scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 16'h0000);

    // 2: pass-through with zero DQ
    reset = 1'b0; DQN = 11'h3A5; DQ = 16'h0000;
    tick();
    check_val("pass_DQN1", {5'd0, DQN1}, 16'h03A5);
    check_val("pass_B", B, 16'h0000);

    // 3: positive agreement
    reset = 1'b1; tick(); reset = 1'b0;
    DQ = 16'h0010; DQN = 11'h020;
    tick(); check_val("pos1_B", B, 16'h0080);
    tick(); check_val("pos2_B", B, 16'h0100);

    // 4: sign disagreement
    reset = 1'b1; tick(); reset = 1'b0;
    DQ = 16'h8010; DQN = 11'h020;
    tick(); check_val("neg1_B", B, 16'hFF80);
    tick(); check_val("neg2_B", B, 16'hFF01);

    // 5: grow B, then leak at both rates
    reset = 1'b1; tick(); reset = 1'b0;
    DQ = 16'h0100; DQN = 11'h011;
    for (int i = 0; i < 120; i++) tick();
    check_model("grow");
    DQ = 16'h0000; RATE = 2'b01;
    tick(); check_model("leak8");
    RATE = 2'b00;
    tick(); check_model("leak9");

    // 6: TR clears B, DQN1 keeps shifting; reset mid-stream
    TR = 1'b1; DQN = 11'h155; DQ = 16'h0040;
    tick();
    check_val("tr_B", B, 16'h0000);
    check_val("tr_DQN1", {5'd0, DQN1}, 16'h0155);
    TR = 1'b0; tick(); tick();
    reset = 1'b1; tick();
    check_val("mid_rst_B", B, 16'h0000);
    check_val("mid_rst_DQN1", {5'd0, DQN1}, 16'h0020);
    reset = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      TR    = ($urandom_range(0, 49) == 0);
      RATE  = 2'($urandom_range(0, 3));
      DQ    = ($urandom_range(0, 5) == 0) ? {1'($urandom), 15'd0} : 16'($urandom);
      DQN   = 11'($urandom);
      scan_enable = 1'($urandom); scan_in0 = 1'($urandom); scan_in3 = 1'($urandom);
      tick();
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
